// File: rtl/adc082s021_pkg.sv
// Constants and types shared by the ADC082S021 driver and its SPI responder model.
// The command word carries a 3-bit channel address at bits [13:11].
package adc082s021_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_LSB   = 11;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 12;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [FRAME_BITS-1:0] word);
    return word[ADDR_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one SPI line with rise/fall strobes on the synchronized value.
// INIT sets the value the line appears to hold while reset is active.
module spi_slave_sync #(
  parameter int   SYNC = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] stage_reg;
  logic            prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= {SYNC{INIT}};
      prev_reg  <= INIT;
    end else begin
      stage_reg <= {stage_reg[SYNC-2:0], d};
      prev_reg  <= stage_reg[SYNC-1];
    end
  end

  assign q    = stage_reg[SYNC-1];
  assign rise = q & ~prev_reg;
  assign fall = ~q & prev_reg;

endmodule

// File: rtl/adc082s021_model.sv
// SPI responder emulating an ADC082S021-family converter: decodes the channel from each
// 16-bit command and returns the sample of the channel addressed in the previous frame.
module adc082s021_model
  import adc082s021_pkg::*;
#(
  parameter int BITS     = 12,
  parameter int CHANNELS = 8,
  parameter int SYNC     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     ss,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [CHANNELS*BITS-1:0] ch_data,
  output logic [ADDR_W-1:0]        channel,
  output logic [FRAME_BITS-1:0]    cmd,
  output logic                     frame_done,
  output logic                     frame_err
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;

  spi_slave_sync #(.SYNC(SYNC), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  // ss resets to "asserted" so a frame already in progress at reset release is never joined.
  spi_slave_sync #(.SYNC(SYNC), .INIT(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(ss), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  spi_slave_sync #(.SYNC(SYNC), .INIT(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_q),
    .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // Output word per address; addresses beyond CHANNELS read as zero.
  logic [FRAME_BITS-1:0] sample_word [2**ADDR_W];

  generate
    for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_sample
      if (gi < CHANNELS) begin : g_live
        assign sample_word[gi] = FRAME_BITS'(ch_data[gi*BITS +: BITS]);
      end else begin : g_zero
        assign sample_word[gi] = '0;
      end
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [FRAME_BITS-1:0] shift_out_reg, shift_out_next;
  logic [FRAME_BITS-1:0] shift_in_reg, shift_in_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  miso_reg, miso_next;
  logic                  oe_reg, oe_next;
  logic [ADDR_W-1:0]     channel_reg, channel_next;
  logic [FRAME_BITS-1:0] cmd_reg, cmd_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= WAIT_IDLE;
      shift_out_reg <= '0;
      shift_in_reg  <= '0;
      cnt_reg       <= '0;
      miso_reg      <= 1'b0;
      oe_reg        <= 1'b0;
      channel_reg   <= '0;
      cmd_reg       <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_out_reg <= shift_out_next;
      shift_in_reg  <= shift_in_next;
      cnt_reg       <= cnt_next;
      miso_reg      <= miso_next;
      oe_reg        <= oe_next;
      channel_reg   <= channel_next;
      cmd_reg       <= cmd_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_out_next = shift_out_reg;
    shift_in_next  = shift_in_reg;
    cnt_next       = cnt_reg;
    miso_next      = miso_reg;
    oe_next        = oe_reg;
    channel_next   = channel_reg;
    cmd_next       = cmd_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      WAIT_IDLE: begin
        if (!ss_q) state_next = IDLE;
      end

      IDLE: begin
        if (ss_rise) begin
          shift_out_next = sample_word[channel_reg];
          shift_in_next  = '0;
          cnt_next       = '0;
          miso_next      = 1'b0;
          oe_next        = 1'b1;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_rise) begin
          miso_next      = shift_out_reg[FRAME_BITS-1];
          shift_out_next = {shift_out_reg[FRAME_BITS-2:0], 1'b0};
        end
        if (sclk_fall) begin
          shift_in_next = {shift_in_reg[FRAME_BITS-2:0], mosi_q};
          cnt_next      = cnt_reg + CNT_W'(1);
        end
        // The last falling edge wins over a coincident ss fall: the frame counts as complete.
        if (sclk_fall && cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
          cmd_next     = shift_in_next;
          channel_next = cmd_addr(shift_in_next);
          done_next    = 1'b1;
          miso_next    = 1'b0;
          state_next   = DONE;
          if (ss_fall) begin
            oe_next    = 1'b0;
            state_next = IDLE;
          end
        end else if (ss_fall) begin
          err_next   = 1'b1;
          miso_next  = 1'b0;
          oe_next    = 1'b0;
          state_next = IDLE;
        end
      end

      DONE: begin
        if (ss_fall) begin
          miso_next  = 1'b0;
          oe_next    = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = WAIT_IDLE;
    endcase
  end

  assign miso       = miso_reg;
  assign miso_oe    = oe_reg;
  assign channel    = channel_reg;
  assign cmd        = cmd_reg;
  assign frame_done = done_reg;
  assign frame_err  = err_reg;

endmodule

// File: tb/tb_adc082s021_model.sv
// Bench for adc082s021_model: the bench acts as SPI master against a default instance and a
// narrow instance (BITS=8, CHANNELS=4); expected frames go through a scoreboard queue.
module tb_adc082s021_model;

  localparam int SYNC = 2;
  localparam int HALF = 6;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] rx4;
    logic [15:0] cmd;
    logic [2:0]  ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        ss = 1'b0;
  logic        mosi = 1'b0;
  logic [95:0] ch_data = '0;
  logic [31:0] ch_data4 = '0;

  logic        miso, miso_oe, frame_done, frame_err;
  logic [2:0]  channel;
  logic [15:0] cmd;
  logic        miso4, miso_oe4, frame_done4, frame_err4;
  logic [2:0]  channel4;
  logic [15:0] cmd4;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0, err_cnt = 0, done4_cnt = 0, err4_cnt = 0;
  exp_t sb_q[$];
  logic [2:0]  model_ch = '0;
  logic [15:0] model_cmd = '0;

  always #5 clk = ~clk;

  adc082s021_model #(.BITS(12), .CHANNELS(8), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .ch_data(ch_data), .channel(channel),
    .cmd(cmd), .frame_done(frame_done), .frame_err(frame_err)
  );

  adc082s021_model #(.BITS(8), .CHANNELS(4), .SYNC(SYNC)) dut4 (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso4), .miso_oe(miso_oe4), .ch_data(ch_data4), .channel(channel4),
    .cmd(cmd4), .frame_done(frame_done4), .frame_err(frame_err4)
  );

  always @(posedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_err)   err_cnt++;
    if (frame_done4) done4_cnt++;
    if (frame_err4)  err4_cnt++;
  end

  function automatic logic [15:0] model_sample(input logic [2:0] ch);
    return {4'b0, ch_data[ch*12 +: 12]};
  endfunction

  function automatic logic [15:0] model_sample4(input logic [2:0] ch);
    if (ch < 4) return {8'b0, ch_data4[ch*8 +: 8]};
    return 16'h0000;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master frame: nbits clock pulses, mosi MSB first, miso captured just before each fall.
  task automatic do_frame(input logic [15:0] cw, input int nbits, input int half,
                          input bit simul, input int chg_bit, input logic [95:0] chg_val,
                          output logic [15:0] rx, output logic [15:0] rx4,
                          output logic oe_mid);
    exp_t e;
    rx = '0;
    rx4 = '0;
    oe_mid = 1'b0;
    if (nbits == 16) begin
      e.rx  = model_sample(model_ch);
      e.rx4 = model_sample4(model_ch);
      e.cmd = cw;
      e.ch  = cw[13:11];
      sb_q.push_back(e);
      model_ch  = cw[13:11];
      model_cmd = cw;
    end
    @(negedge clk);
    ss = 1'b1;
    wait_clks(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) ch_data = chg_val;
      sclk = 1'b1;
      mosi = cw[15-i];
      wait_clks(half);
      rx  = {rx[14:0], miso};
      rx4 = {rx4[14:0], miso4};
      if (i == nbits / 2) oe_mid = miso_oe;
      sclk = 1'b0;
      if (simul && i == nbits - 1) ss = 1'b0;
      wait_clks(half);
    end
    ss = 1'b0;
    mosi = 1'b0;
    wait_clks(SYNC + 4);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clks(3);
    checks++; if (miso !== 1'b0)      begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (miso_oe !== 1'b0)   begin errors++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
    checks++; if (channel !== 3'd0)   begin errors++; $display("FAIL reset_channel: got %0d expected 0", channel); end
    checks++; if (cmd !== 16'h0000)   begin errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
    checks++; if (frame_done !== 1'b0 || frame_err !== 1'b0)
      begin errors++; $display("FAIL reset_strobes: got done=%b err=%b expected 0 0", frame_done, frame_err); end
    reset = 1'b0;
    wait_clks(SYNC + 4);
    $display("test_reset: outputs at reset values");
  endtask

  task automatic test_basic;
    logic [15:0] rx, rx4;
    logic oe_mid;
    exp_t e;
    int d0, r0;
    for (int f = 0; f < 2; f++) begin
      d0 = done_cnt; r0 = err_cnt;
      do_frame(16'h0800, 16, HALF, 1'b0, -1, ch_data, rx, rx4, oe_mid);
      e = sb_q.pop_front();
      checks++; if (rx !== e.rx)   begin errors++; $display("FAIL basic_rx%0d: got %h expected %h", f, rx, e.rx); end
      checks++; if (rx4 !== e.rx4) begin errors++; $display("FAIL basic_rx4_%0d: got %h expected %h", f, rx4, e.rx4); end
      checks++; if (cmd !== e.cmd) begin errors++; $display("FAIL basic_cmd%0d: got %h expected %h", f, cmd, e.cmd); end
      checks++; if (channel !== e.ch) begin errors++; $display("FAIL basic_ch%0d: got %0d expected %0d", f, channel, e.ch); end
      checks++; if (oe_mid !== 1'b1) begin errors++; $display("FAIL basic_oe%0d: got %b expected 1", f, oe_mid); end
      checks++; if (done_cnt - d0 != 1 || err_cnt != r0)
        begin errors++; $display("FAIL basic_strobe%0d: got done+%0d err+%0d expected 1 0", f, done_cnt - d0, err_cnt - r0); end
      $display("test_basic frame %0d: rx=%h cmd=%h channel=%0d", f, rx, cmd, channel);
    end
  endtask

  task automatic test_midframe_change;
    logic [15:0] rx, rx4;
    logic oe_mid;
    logic [95:0] nv;
    exp_t e;
    nv = ch_data;
    nv[23:12] = 12'h120;
    for (int f = 0; f < 2; f++) begin
      do_frame(16'h0800, 16, HALF, 1'b0, (f == 0) ? 8 : -1, nv, rx, rx4, oe_mid);
      e = sb_q.pop_front();
      checks++; if (rx !== e.rx) begin errors++; $display("FAIL midchg_rx%0d: got %h expected %h", f, rx, e.rx); end
      $display("test_midframe_change frame %0d: rx=%h", f, rx);
    end
  endtask

  task automatic test_abort;
    logic [15:0] rx, rx4;
    logic oe_mid;
    exp_t e;
    int d0, r0, r40;
    d0 = done_cnt; r0 = err_cnt; r40 = err4_cnt;
    do_frame(16'h1000, 9, HALF, 1'b0, -1, ch_data, rx, rx4, oe_mid);
    checks++; if (err_cnt - r0 != 1) begin errors++; $display("FAIL abort_err: got %0d pulses expected 1", err_cnt - r0); end
    checks++; if (err4_cnt - r40 != 1) begin errors++; $display("FAIL abort_err4: got %0d pulses expected 1", err4_cnt - r40); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0); end
    checks++; if (channel !== model_ch) begin errors++; $display("FAIL abort_channel: got %0d expected %0d", channel, model_ch); end
    checks++; if (cmd !== model_cmd) begin errors++; $display("FAIL abort_cmd: got %h expected %h", cmd, model_cmd); end
    checks++; if (miso !== 1'b0 || miso_oe !== 1'b0)
      begin errors++; $display("FAIL abort_miso: got miso=%b oe=%b expected 0 0", miso, miso_oe); end
    $display("test_abort: err pulses=%0d channel=%0d cmd=%h", err_cnt - r0, channel, cmd);
    do_frame(16'h1000, 16, HALF, 1'b0, -1, ch_data, rx, rx4, oe_mid);
    e = sb_q.pop_front();
    checks++; if (rx !== e.rx) begin errors++; $display("FAIL abort_next_rx: got %h expected %h", rx, e.rx); end
    checks++; if (channel !== e.ch) begin errors++; $display("FAIL abort_next_ch: got %0d expected %0d", channel, e.ch); end
    $display("test_abort next frame: rx=%h channel=%0d", rx, channel);
  endtask

  task automatic test_reset_midframe;
    logic [15:0] rx, rx4;
    logic oe_mid;
    exp_t e;
    int d0, r0;
    @(negedge clk);
    ss = 1'b1;
    wait_clks(HALF);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1; wait_clks(HALF);
      sclk = 1'b0; wait_clks(HALF);
    end
    reset = 1'b1;
    model_ch = '0;
    model_cmd = '0;
    wait_clks(2);
    checks++; if (miso !== 1'b0 || miso_oe !== 1'b0 || channel !== 3'd0 || cmd !== 16'h0000)
      begin errors++; $display("FAIL rstmid_outputs: got miso=%b oe=%b ch=%0d cmd=%h expected 0 0 0 0000", miso, miso_oe, channel, cmd); end
    reset = 1'b0;
    d0 = done_cnt; r0 = err_cnt;
    for (int i = 0; i < 16; i++) begin
      sclk = 1'b1; wait_clks(HALF);
      sclk = 1'b0; wait_clks(HALF);
    end
    checks++; if (miso_oe !== 1'b0 || done_cnt != d0 || err_cnt != r0)
      begin errors++; $display("FAIL rstmid_quiet: got oe=%b done+%0d err+%0d expected 0 0 0", miso_oe, done_cnt - d0, err_cnt - r0); end
    ss = 1'b0;
    wait_clks(SYNC + 4);
    do_frame(16'h1800, 16, HALF, 1'b0, -1, ch_data, rx, rx4, oe_mid);
    e = sb_q.pop_front();
    checks++; if (rx !== e.rx) begin errors++; $display("FAIL rstmid_rx: got %h expected %h", rx, e.rx); end
    checks++; if (channel !== e.ch) begin errors++; $display("FAIL rstmid_ch: got %0d expected %0d", channel, e.ch); end
    $display("test_reset_midframe: next rx=%h channel=%0d", rx, channel);
  endtask

  task automatic test_simultaneous;
    logic [15:0] rx, rx4;
    logic oe_mid;
    exp_t e;
    int d0, r0;
    d0 = done_cnt; r0 = err_cnt;
    do_frame(16'h2000, 16, HALF, 1'b1, -1, ch_data, rx, rx4, oe_mid);
    e = sb_q.pop_front();
    checks++; if (done_cnt - d0 != 1 || err_cnt != r0)
      begin errors++; $display("FAIL simul_strobe: got done+%0d err+%0d expected 1 0", done_cnt - d0, err_cnt - r0); end
    checks++; if (cmd !== e.cmd || channel !== e.ch)
      begin errors++; $display("FAIL simul_cmd: got %h/%0d expected %h/%0d", cmd, channel, e.cmd, e.ch); end
    checks++; if (rx !== e.rx) begin errors++; $display("FAIL simul_rx: got %h expected %h", rx, e.rx); end
    checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL simul_oe: got %b expected 0", miso_oe); end
    $display("test_simultaneous: rx=%h cmd=%h channel=%0d", rx, cmd, channel);
  endtask

  task automatic test_stress;
    logic [15:0] rx, rx4, cw;
    logic oe_mid;
    exp_t e;
    int d40;
    ch_data  = {$urandom(), $urandom(), $urandom()};
    ch_data4 = $urandom();
    for (int k = 0; k < 9; k++) begin
      cw = 16'(k % 8) << 11;
      d40 = done4_cnt;
      do_frame(cw, 16, SYNC + 2, 1'b0, -1, ch_data, rx, rx4, oe_mid);
      e = sb_q.pop_front();
      checks++; if (rx !== e.rx)   begin errors++; $display("FAIL stress_rx%0d: got %h expected %h", k, rx, e.rx); end
      checks++; if (rx4 !== e.rx4) begin errors++; $display("FAIL stress_rx4_%0d: got %h expected %h", k, rx4, e.rx4); end
      checks++; if (channel !== e.ch || channel4 !== e.ch)
        begin errors++; $display("FAIL stress_ch%0d: got %0d/%0d expected %0d", k, channel, channel4, e.ch); end
      checks++; if (done4_cnt - d40 != 1) begin errors++; $display("FAIL stress_done4_%0d: got %0d expected 1", k, done4_cnt - d40); end
      $display("test_stress frame %0d: cmd=%h rx=%h rx4=%h", k, cw, rx, rx4);
    end
  endtask

  initial begin
    ch_data[11:0]  = 12'h0aa;
    ch_data[23:12] = 12'hff0;
    for (int i = 2; i < 8; i++) ch_data[i*12 +: 12] = 12'(12'h101 * i);
    ch_data4 = 32'h44_33_22_11;
    test_reset();
    test_basic();
    test_midframe_change();
    test_abort();
    test_reset_midframe();
    test_simultaneous();
    test_stress();
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc082s021_model.md
Name: adc082s021_model

Overview:
- Synthesizable SPI responder that emulates the ADC082S021-family converter on the far end of the bus driven by the adc082s021 driver and spi_master_ctrl.
- Decodes the channel address from each 16-bit command frame.
- Returns the sample of the channel addressed in the previous frame, taken from a parallel input bus.
- Used as a loopback target in system benches and as an on-FPGA stand-in when the physical ADC is absent.

Parameters:
- BITS, 12, sample width per channel; must be ≤ 12.
- CHANNELS, 8, number of channel inputs; must be ≤ 8, since the address field is 3 bits.
- SYNC, 2, synchronizer flop stages on sclk/ss/mosi; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from the master, asynchronous to clk.
- ss  input  1  slave select, active-high (asserted while a frame is in progress).
- mosi  input  1  command data from the master.
- miso  output  1  conversion data to the master.
- miso_oe  output  1  high while selected; used to drive an external tristate.
- ch_data  input  CHANNELS*BITS  channel samples; channel n occupies bits [n*BITS +: BITS].
- channel  output  3  address to be converted in the next frame.
- cmd  output  16  last complete command word received.
- frame_done  output  1  one-clk strobe on each completed 16-bit frame.
- frame_err  output  1  one-clk strobe when ss deasserts before 16 falling sclk edges.

Behaviour:
- Reset values: miso=0, miso_oe=0, channel=0, cmd=0, frame_done=0, frame_err=0; FSM enters WAIT_IDLE.
- Input conditioning:
  - sclk, ss and mosi each pass through SYNC flops.
  - Rise and fall of sclk and ss are detected on synchronized values.
  - Edge-to-action latency is SYNC+1 clk cycles.
  - Requirement on the master: sclk high and low times ≥ SYNC+2 clk periods.
- FSM states and transitions:
  - WAIT_IDLE: stay until synchronized ss=0, then go to IDLE. Prevents joining a frame mid-way after reset.
  - IDLE: on ss rise:
    - load shift_out = {(16-BITS)'b0, sample of channel}; an out-of-range channel (≥ CHANNELS) yields zero data.
    - clear bit counter and shift_in; set miso=0, miso_oe=1; go to SHIFT.
  - SHIFT:
    - on sclk rise: miso = shift_out[15]; shift shift_out left, filling 0.
    - on sclk fall: shift_in = {shift_in[14:0], mosi}; bit counter +1.
    - when the counter reaches 16: go to DONE.
    - on ss fall with counter < 16: pulse frame_err; channel and cmd are unchanged; miso=0, miso_oe=0; go to IDLE.
  - DONE:
    - cmd = shift_in; channel = shift_in[13:11]; pulse frame_done once.
    - further sclk edges are ignored, and miso stays 0.
    - on ss fall: miso_oe=0; go to IDLE.
- Command bit mapping: command 16'h0800 → channel 1; 16'h3800 → channel 7. All other command bits are ignored.
- Pipelining: the sample is latched at ss rise, so a ch_data change mid-frame does not affect the frame in flight.
- Output frame: bits 15..12 = 0, bits 11..0 = sample MSB-first, left-padded with zeros when BITS < 12.
- Simultaneous events:
  - ss fall coinciding with the 16th sclk fall (same synchronized cycle): counts as complete. frame_done fires and frame_err does not.
  - reset mid-frame: all outputs go to their reset values and the FSM returns to WAIT_IDLE.

Decomposition:
- Shared package adc082s021_pkg holds constants used by both driver and model: FRAME_BITS=16, ADDR_LSB=11, ADDR_W=3, DATA_W=12.
- Sub-module spi_slave_sync contains the parameterized synchronizer plus rise/fall edge detector, one instance per signal. It is reusable by other SPI responders.

Test Plan:
- adc082s021 driver with channel=1 against this model; ch_data ch0=12'h0aa, ch1=12'hff0. First frame → driver data 12'h0aa, cmd=16'h0800, channel=1. Second frame → driver data 12'hff0.
- Change ch1 to 12'h120 mid-frame → that frame still returns the old value; the next frame returns 12'h120.
- Abort: drop ss after 9 sclk falls → frame_err pulses once, channel and cmd are unchanged, miso=0. The following full frame succeeds.
- Reset asserted during bit 5 with ss held high → outputs go to reset values and no activity occurs until ss low is seen. The next frame reads ch0.
- Stress: run spi_master_ctrl at the minimum sclk half-period (SYNC+2 clks) over 8 frames sweeping channels 0–7 → each returned value matches the previous frame's channel. With CHANNELS=4, address 5 returns 0.
